// File: rtl/matrix_dispatch_pkg.sv
// Shared types and constants for the matrix dispatch stage: opcodes, the
// issue packet, the register status table view and the output-slot states.
package matrix_dispatch_pkg;

  localparam int NMREGS  = 16;
  localparam int NMTAGS  = 4;
  localparam int MREG_W  = 4;
  localparam int MTAG_W  = 2;

  typedef enum logic [1:0] {
    MOP_MLOAD  = 2'd0,
    MOP_MSTORE = 2'd1,
    MOP_GEMM   = 2'd2,
    MOP_RSVD   = 2'd3
  } mop_t;

  typedef struct packed {
    mop_t              op;
    logic [MREG_W-1:0] rd;
    logic [MREG_W-1:0] rs1;
    logic [MREG_W-1:0] rs2;
    logic [MREG_W-1:0] rs3;
    logic [MTAG_W-1:0] tag;
  } mdisp_t;

  typedef struct packed {
    logic [NMREGS-1:0]             busy;
    logic [NMREGS-1:0][MTAG_W-1:0] tag;
  } rst_m_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Scanning from the top down leaves the lowest set index as the result.
  function automatic logic [MTAG_W-1:0] lowest_free(input logic [NMTAGS-1:0] map);
    lowest_free = '0;
    for (int i = NMTAGS - 1; i >= 0; i--) begin
      if (map[i]) lowest_free = MTAG_W'(i);
    end
  endfunction

endpackage

// File: rtl/matrix_dispatch_if.sv
// Decoded-instruction input bundle and issue-packet output bundle of the
// matrix dispatch stage.
interface matrix_dispatch_if;
  import matrix_dispatch_pkg::*;

  logic              in_valid;
  logic              in_ready;
  mop_t              in_op;
  logic [MREG_W-1:0] in_rd;
  logic [MREG_W-1:0] in_rs1;
  logic [MREG_W-1:0] in_rs2;
  logic [MREG_W-1:0] in_rs3;

  logic              out_valid;
  logic              out_ready;
  mdisp_t            out_pkt;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_rs3, out_ready,
    input  in_ready, out_valid, out_pkt
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_rs3, out_ready,
    output in_ready, out_valid, out_pkt
  );

endinterface

// File: rtl/matrix_dispatch_mtag_alloc.sv
// In-flight tag allocator: free bitmap, lowest-free priority pick and
// retire handling.
module mtag_alloc
  import matrix_dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  output logic [MTAG_W-1:0] alloc_tag,
  output logic              alloc_ok,
  input  logic              free_valid,
  input  logic [MTAG_W-1:0] free_tag
);

  logic [NMTAGS-1:0] free_q;
  logic [NMTAGS-1:0] free_d;

  assign alloc_ok  = |free_q;
  assign alloc_tag = lowest_free(free_q);

  // Retire is applied before allocate, so a retire aimed at the tag being
  // allocated (necessarily already free) cannot undo the allocation.
  always_comb begin
    free_d = free_q;
    if (free_valid) free_d[free_tag] = 1'b1;
    if (alloc_req && alloc_ok) free_d[alloc_tag] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) free_q <= '1;
    else        free_q <= free_d;
  end

endmodule

// File: rtl/matrix_dispatch.sv
// Matrix instruction dispatch: hazard check against the register status
// table, tag allocation, RST dispatch write and a one-entry issue register.
module matrix_dispatch
  import matrix_dispatch_pkg::*;
#(
  parameter int STALL_W = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  matrix_dispatch_if.slave   dsp,
  input  rst_m_t             status,
  output logic [MREG_W-1:0]  di_sel,
  output logic               di_write,
  output logic [MTAG_W-1:0]  di_tag,
  input  logic               wb_valid,
  input  logic [MTAG_W-1:0]  wb_tag,
  output logic [STALL_W-1:0] stall_cnt
);

  slot_state_e        state_q, state_d;
  mdisp_t             pkt_q, pkt_d;
  logic [STALL_W-1:0] stallCnt_q, stallCnt_d;

  logic              isGemm, isStore, isRsvd, writesRd;
  logic              rawHaz, wawHaz, hazard;
  logic              tagOk, slotOk, accept, issue;
  logic [MTAG_W-1:0] allocTag;
  logic              unusedStatusTag;

  // Hazards use only the registered status; the RST tag field is not needed.
  assign unusedStatusTag = ^status.tag;

  always_comb begin
    isGemm   = (dsp.in_op == MOP_GEMM);
    isStore  = (dsp.in_op == MOP_MSTORE);
    isRsvd   = (dsp.in_op == MOP_RSVD);
    writesRd = (dsp.in_op == MOP_MLOAD) || isGemm;

    rawHaz = (isGemm && (status.busy[dsp.in_rs1] || status.busy[dsp.in_rs2] ||
                         status.busy[dsp.in_rs3])) ||
             (isStore && status.busy[dsp.in_rs1]);
    wawHaz = writesRd && status.busy[dsp.in_rd];
    hazard = rawHaz || wawHaz;

    slotOk = (state_q == SLOT_EMPTY) || dsp.out_ready;
    if (isRsvd) accept = dsp.in_valid && slotOk;
    else        accept = dsp.in_valid && !hazard && tagOk && slotOk;
    issue = accept && !isRsvd;
  end

  assign dsp.in_ready = accept;

  mtag_alloc u_tags (
    .clk        (CLK),
    .rst_n      (nRST),
    .alloc_req  (issue),
    .alloc_tag  (allocTag),
    .alloc_ok   (tagOk),
    .free_valid (wb_valid),
    .free_tag   (wb_tag)
  );

  always_comb begin
    di_write = accept && writesRd;
    di_sel   = di_write ? dsp.in_rd : '0;
    di_tag   = di_write ? allocTag  : '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= SLOT_EMPTY;
    else       state_q <= state_d;
  end

  // A reserved op that is accepted while full still lets the slot drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (issue) state_d = SLOT_FULL;
      SLOT_FULL:  if (!issue && dsp.out_ready) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    dsp.out_valid = (state_q == SLOT_FULL);
    dsp.out_pkt   = pkt_q;
  end

  always_comb begin
    pkt_d = pkt_q;
    if (issue) begin
      pkt_d.op  = dsp.in_op;
      pkt_d.rd  = dsp.in_rd;
      pkt_d.rs1 = dsp.in_rs1;
      pkt_d.rs2 = dsp.in_rs2;
      pkt_d.rs3 = dsp.in_rs3;
      pkt_d.tag = allocTag;
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (dsp.in_valid && hazard && !(&stallCnt_q)) stallCnt_d = stallCnt_q + STALL_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pkt_q      <= '0;
      stallCnt_q <= '0;
    end else begin
      pkt_q      <= pkt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_matrix_dispatch.sv
// Directed and randomized bench for matrix_dispatch; the random phase acts
// as the RST and predicts every output from a behavioural model.
module tb_matrix_dispatch;
  import matrix_dispatch_pkg::*;

  logic        CLK;
  logic        nRST;
  rst_m_t      status;
  logic [3:0]  di_sel;
  logic        di_write;
  logic [1:0]  di_tag;
  logic        wb_valid;
  logic [1:0]  wb_tag;
  logic [15:0] stall_cnt;

  int total;
  int bad;

  matrix_dispatch_if dif ();

  matrix_dispatch #(.STALL_W(16)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .dsp       (dif),
    .status    (status),
    .di_sel    (di_sel),
    .di_write  (di_write),
    .di_tag    (di_tag),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .stall_cnt (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input mop_t op, input logic [3:0] rd,
                               input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rs3);
    dif.in_valid = v;
    dif.in_op    = op;
    dif.in_rd    = rd;
    dif.in_rs1   = rs1;
    dif.in_rs2   = rs2;
    dif.in_rs3   = rs3;
  endtask

  task automatic idle();
    applyStimulus(1'b0, MOP_MLOAD, 4'd0, 4'd0, 4'd0, 4'd0);
    wb_valid = 1'b0;
    wb_tag   = 2'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    nRST = 1'b0;
    idle();
    status = '0;
    dif.out_ready = 1'b1;
    tick();
    nRST = 1'b1;
  endtask

  // Behavioural model state for the random phase.
  logic        freeM [4];
  logic [15:0] busyM;
  logic [1:0]  tagM [16];
  logic        ovM;
  mdisp_t      pktM;
  logic [15:0] stallM;

  initial begin
    logic       haz;
    logic       slot;
    logic       expAcc;
    logic       expWr;
    int         freeTag;
    mop_t       op;
    logic [3:0] rd, r1, r2, r3;

    total = 0;
    bad   = 0;

    nRST = 1'b0;
    status = '0;
    dif.out_ready = 1'b1;
    idle();
    #1;
    checkOutput("rst_out_valid", dif.out_valid, 0);
    checkOutput("rst_out_pkt",   dif.out_pkt,   0);
    checkOutput("rst_stall_cnt", stall_cnt,     0);
    checkOutput("rst_in_ready",  dif.in_ready,  0);
    checkOutput("rst_di_write",  di_write,      0);
    checkOutput("rst_di_sel",    di_sel,        0);
    checkOutput("rst_di_tag",    di_tag,        0);
    tick();
    tick();
    nRST = 1'b1;

    $display("[TB] first GEMM");
    applyStimulus(1'b1, MOP_GEMM, 4'd3, 4'd1, 4'd2, 4'd4);
    @(negedge CLK);
    checkOutput("gemm_in_ready", dif.in_ready, 1);
    checkOutput("gemm_di_write", di_write, 1);
    checkOutput("gemm_di_sel",   di_sel,   3);
    checkOutput("gemm_di_tag",   di_tag,   0);
    tick();
    idle();
    checkOutput("gemm_out_valid", dif.out_valid,   1);
    checkOutput("gemm_pkt_tag",   dif.out_pkt.tag, 0);
    checkOutput("gemm_pkt_op",    dif.out_pkt.op,  MOP_GEMM);
    checkOutput("gemm_pkt_rd",    dif.out_pkt.rd,  3);

    $display("[TB] hazard stall");
    doReset();
    status.busy[2] = 1'b1;
    applyStimulus(1'b1, MOP_GEMM, 4'd5, 4'd1, 4'd2, 4'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("haz_in_ready", dif.in_ready, 0);
      checkOutput("haz_di_write", di_write, 0);
      tick();
    end
    checkOutput("haz_stall_cnt", stall_cnt, 5);
    status.busy[2] = 1'b0;
    @(negedge CLK);
    checkOutput("haz_clear_in_ready", dif.in_ready, 1);
    checkOutput("haz_clear_di_write", di_write, 1);
    tick();
    idle();
    checkOutput("haz_stall_hold", stall_cnt, 5);
    checkOutput("haz_out_valid",  dif.out_valid, 1);
    checkOutput("haz_pkt_rd",     dif.out_pkt.rd, 5);

    $display("[TB] tag exhaustion");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, MOP_MLOAD, 4'(i), 4'd0, 4'd0, 4'd0);
      @(negedge CLK);
      checkOutput("tags_in_ready", dif.in_ready, 1);
      checkOutput("tags_di_tag",   di_tag, i);
      tick();
    end
    applyStimulus(1'b1, MOP_MLOAD, 4'd5, 4'd0, 4'd0, 4'd0);
    @(negedge CLK);
    checkOutput("tags_full_in_ready", dif.in_ready, 0);
    tick();
    checkOutput("tags_full_no_stall", stall_cnt, 0);
    wb_valid = 1'b1;
    wb_tag   = 2'd2;
    @(negedge CLK);
    checkOutput("tags_freeing_in_ready", dif.in_ready, 0);
    tick();
    wb_valid = 1'b0;
    @(negedge CLK);
    checkOutput("tags_freed_in_ready", dif.in_ready, 1);
    checkOutput("tags_freed_di_tag",   di_tag, 2);
    tick();
    idle();
    checkOutput("tags_pkt_tag", dif.out_pkt.tag, 2);
    checkOutput("tags_pkt_rd",  dif.out_pkt.rd,  5);

    $display("[TB] backpressure");
    doReset();
    dif.out_ready = 1'b0;
    applyStimulus(1'b1, MOP_MLOAD, 4'd1, 4'd0, 4'd0, 4'd0);
    @(negedge CLK);
    checkOutput("bp_first_in_ready", dif.in_ready, 1);
    tick();
    applyStimulus(1'b1, MOP_MLOAD, 4'd2, 4'd0, 4'd0, 4'd0);
    checkOutput("bp_out_valid", dif.out_valid, 1);
    checkOutput("bp_pkt_rd",    dif.out_pkt.rd, 1);
    @(negedge CLK);
    checkOutput("bp_second_blocked", dif.in_ready, 0);
    tick();
    tick();
    checkOutput("bp_pkt_stable_rd",  dif.out_pkt.rd,  1);
    checkOutput("bp_pkt_stable_tag", dif.out_pkt.tag, 0);
    checkOutput("bp_still_valid",    dif.out_valid,   1);
    dif.out_ready = 1'b1;
    @(negedge CLK);
    checkOutput("bp_release_in_ready", dif.in_ready, 1);
    checkOutput("bp_release_di_tag",   di_tag, 1);
    tick();
    idle();
    checkOutput("bp_replaced_rd",    dif.out_pkt.rd,  2);
    checkOutput("bp_replaced_tag",   dif.out_pkt.tag, 1);
    checkOutput("bp_replaced_valid", dif.out_valid,   1);
    tick();
    checkOutput("bp_drained", dif.out_valid, 0);

    $display("[TB] MSTORE and reserved op");
    doReset();
    status.busy[3] = 1'b1;
    applyStimulus(1'b1, MOP_MSTORE, 4'd3, 4'd7, 4'd3, 4'd3);
    @(negedge CLK);
    checkOutput("st_in_ready", dif.in_ready, 1);
    checkOutput("st_di_write", di_write, 0);
    tick();
    applyStimulus(1'b1, MOP_MLOAD, 4'd9, 4'd0, 4'd0, 4'd0);
    checkOutput("st_out_valid", dif.out_valid,   1);
    checkOutput("st_pkt_op",    dif.out_pkt.op,  MOP_MSTORE);
    checkOutput("st_pkt_tag",   dif.out_pkt.tag, 0);
    checkOutput("st_pkt_rs1",   dif.out_pkt.rs1, 7);
    @(negedge CLK);
    checkOutput("st_next_di_tag", di_tag, 1);
    tick();
    applyStimulus(1'b1, MOP_RSVD, 4'd3, 4'd3, 4'd3, 4'd3);
    @(negedge CLK);
    checkOutput("rsvd_in_ready", dif.in_ready, 1);
    checkOutput("rsvd_di_write", di_write, 0);
    tick();
    checkOutput("rsvd_no_issue", dif.out_valid, 0);
    applyStimulus(1'b1, MOP_MLOAD, 4'd10, 4'd0, 4'd0, 4'd0);
    @(negedge CLK);
    checkOutput("rsvd_no_tag_di_tag", di_tag, 2);
    tick();
    idle();

    $display("[TB] stall counter saturation");
    doReset();
    status.busy[1] = 1'b1;
    applyStimulus(1'b1, MOP_GEMM, 4'd0, 4'd1, 4'd0, 4'd0);
    repeat (65540) @(posedge CLK);
    #1;
    checkOutput("sat_stall_cnt", stall_cnt, 16'hFFFF);
    checkOutput("sat_in_ready",  dif.in_ready, 0);
    idle();

    $display("[TB] async reset mid-operation");
    doReset();
    status.busy[6] = 1'b1;
    applyStimulus(1'b1, MOP_GEMM, 4'd0, 4'd6, 4'd0, 4'd0);
    tick();
    status = '0;
    applyStimulus(1'b1, MOP_MLOAD, 4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    applyStimulus(1'b1, MOP_MLOAD, 4'd1, 4'd0, 4'd0, 4'd0);
    tick();
    idle();
    dif.out_ready = 1'b0;
    tick();
    checkOutput("mid_pre_valid", dif.out_valid, 1);
    checkOutput("mid_pre_stall", stall_cnt, 1);
    #2 nRST = 1'b0;
    #1;
    checkOutput("mid_rst_valid", dif.out_valid, 0);
    checkOutput("mid_rst_pkt",   dif.out_pkt,   0);
    checkOutput("mid_rst_stall", stall_cnt,     0);
    tick();
    nRST = 1'b1;
    dif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, MOP_MLOAD, 4'(8 + i), 4'd0, 4'd0, 4'd0);
      @(negedge CLK);
      checkOutput("mid_tags_free", di_tag, i);
      tick();
    end
    idle();

    $display("[TB] randomized run against reference model");
    doReset();
    for (int t = 0; t < 4; t++) freeM[t] = 1'b1;
    for (int r = 0; r < 16; r++) tagM[r] = 2'd0;
    busyM  = '0;
    ovM    = 1'b0;
    pktM   = '0;
    stallM = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      op = mop_t'($urandom_range(0, 3));
      rd = 4'($urandom_range(0, 7));
      r1 = 4'($urandom_range(0, 7));
      r2 = 4'($urandom_range(0, 7));
      r3 = 4'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 3) != 0, op, rd, r1, r2, r3);
      dif.out_ready = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_tag   = 2'($urandom_range(0, 3));
      status.busy = busyM;
      for (int r = 0; r < 16; r++) status.tag[r] = tagM[r];

      haz = 1'b0;
      if (op == MOP_GEMM)   haz = busyM[r1] | busyM[r2] | busyM[r3];
      if (op == MOP_MSTORE) haz = busyM[r1];
      if (op == MOP_MLOAD || op == MOP_GEMM) haz = haz | busyM[rd];
      freeTag = -1;
      for (int t = 3; t >= 0; t--) if (freeM[t]) freeTag = t;
      slot = !ovM || dif.out_ready;
      if (op == MOP_RSVD) expAcc = dif.in_valid && slot;
      else                expAcc = dif.in_valid && !haz && (freeTag >= 0) && slot;
      expWr = expAcc && (op == MOP_MLOAD || op == MOP_GEMM);

      @(negedge CLK);
      checkOutput("rnd_in_ready",  dif.in_ready,  expAcc);
      checkOutput("rnd_di_write",  di_write,      expWr);
      checkOutput("rnd_di_sel",    di_sel,        expWr ? rd : 4'd0);
      checkOutput("rnd_di_tag",    di_tag,        expWr ? 2'(freeTag) : 2'd0);
      checkOutput("rnd_out_valid", dif.out_valid, ovM);
      checkOutput("rnd_stall_cnt", stall_cnt,     stallM);
      if (ovM) begin
        checkOutput("rnd_pkt_op",  dif.out_pkt.op,  pktM.op);
        checkOutput("rnd_pkt_tag", dif.out_pkt.tag, pktM.tag);
        checkOutput("rnd_pkt_rs1", dif.out_pkt.rs1, pktM.rs1);
        if (pktM.op != MOP_MSTORE) checkOutput("rnd_pkt_rd", dif.out_pkt.rd, pktM.rd);
        if (pktM.op == MOP_GEMM) begin
          checkOutput("rnd_pkt_rs2", dif.out_pkt.rs2, pktM.rs2);
          checkOutput("rnd_pkt_rs3", dif.out_pkt.rs3, pktM.rs3);
        end
      end

      if (dif.in_valid && haz && stallM != 16'hFFFF) stallM = stallM + 16'd1;
      if (wb_valid && !freeM[wb_tag]) begin
        for (int r = 0; r < 16; r++) if (busyM[r] && tagM[r] == wb_tag) busyM[r] = 1'b0;
      end
      if (wb_valid) freeM[wb_tag] = 1'b1;
      if (expAcc && op != MOP_RSVD) begin
        freeM[freeTag] = 1'b0;
        ovM      = 1'b1;
        pktM.op  = op;
        pktM.rd  = rd;
        pktM.rs1 = r1;
        pktM.rs2 = r2;
        pktM.rs3 = r3;
        pktM.tag = 2'(freeTag);
      end else if (dif.out_ready) begin
        ovM = 1'b0;
      end
      if (expWr) begin
        busyM[rd] = 1'b1;
        tagM[rd]  = 2'(freeTag);
      end
      tick();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
